chimera_cluster_sequencer: RTL and testbench
============================================

Name: chimera_cluster_sequencer

Overview:
Parametrised per-cluster power-up/power-down sequencer for the Chimera accelerator clusters. It generalises the current one-clock-gate-per-cluster scheme into an ordered sequence for each cluster: clock enable, reset release, isolation release and drain-before-off. An inrush limiter caps how many clusters may be in transition at the same time. It sits in the top-level register domain, with its outputs driving the cluster clock gates, resets and AXI isolators.

Parameters:
NumClusters, 5, number of external clusters sequenced (1..32)
MaxActive, 2, maximum clusters simultaneously in a transitional state (1..NumClusters)
ClkSettleCycles, 4, cycles clock runs under reset (power-up) or reset is held before clock stop (power-down); >=1
IsoSettleCycles, 2, cycles reset is released before isolation drops; >=1
DrainTimeout, 256, maximum cycles waiting for busy_i low in DRAIN; >=1

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
en_req_i  in  NumClusters  requested power target per cluster (1=on), level
busy_i  in  NumClusters  cluster has outstanding AXI transactions
err_clr_i  in  NumClusters  clear sticky error, one pulse per bit
clk_en_o  out  NumClusters  cluster clock-gate enable
cluster_rst_o  out  NumClusters  cluster reset, active-high
iso_o  out  NumClusters  AXI isolation enable
on_o  out  NumClusters  cluster fully on
err_o  out  NumClusters  sticky drain-timeout flag
seq_busy_o  out  1  any cluster in a transitional state

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: clk_en_o=0, cluster_rst_o=all 1, iso_o=all 1, on_o=0, err_o=0, seq_busy_o=0; all FSMs in OFF; token count 0. A reset asserted mid-sequence returns every cluster to OFF in the following cycle, with no drain.
- Per-cluster states and outputs (clk_en, rst, iso, on):
  - OFF (0,1,1,0)
  - CLK_ON (1,1,1,0)
  - DERST (1,0,1,0)
  - ON (1,0,0,1)
  - DRAIN (1,0,1,0)
  - RST (1,1,1,0)
- Pending requests:
  - OFF with en_req_i=1 is pending-up.
  - ON with en_req_i=0 is pending-down.
  - Other states are never pending.
- Arbitration:
  - Each cycle, if tokens < MaxActive, grant the lowest-index pending cluster.
  - At most one grant per cycle.
  - A grant takes a token and moves the FSM on the next edge.
- Power-up: OFF->CLK_ON (ClkSettleCycles cycles) -> DERST (IsoSettleCycles cycles) -> ON. Token released on entering ON. on_o rises 1+ClkSettle+IsoSettle cycles after the grant cycle.
- Power-down sequence:
  - Granted ON moves to DRAIN; iso_o=1 and on_o=0 take effect on the next edge.
  - Stay in DRAIN until busy_i=0 is sampled, then go to RST.
  - If DrainTimeout cycles elapse with busy_i=1, set err_o and go to RST anyway.
  - RST holds ClkSettleCycles cycles, then OFF. Token released on entering OFF.
- Requests that change during a transition are ignored until the FSM reaches ON or OFF. Each change is then re-arbitrated; no abort.
- Counters: one per cluster, width $clog2(max(ClkSettle,IsoSettle,DrainTimeout)+1). Cleared on every state entry. No wrap.
- err_o is sticky. It is cleared by err_clr_i. If set and clear occur in the same cycle, set wins.
- seq_busy_o = OR over clusters of (state not in {OFF, ON}).
- The token counter never exceeds MaxActive. A release and a grant in the same cycle leave the count unchanged.

Decomposition:
- chimera_pkg additions:
  - cluster_seq_state_e enum (OFF, CLK_ON, DERST, ON, DRAIN, RST, 3-bit)
  - default constants ClusterClkSettleCycles=4, ClusterIsoSettleCycles=2, ClusterDrainTimeout=256
  - NumClusters bound to ExtClusters
- Sub-module chimera_cluster_seq_fsm, instantiated per cluster. It holds the FSM, counter and err flag, with grant_i, pend_up_o, pend_down_o and release_o.
- The top level holds the token counter and the lowest-index priority arbiter.

Test Plan:
1. After reset, en_req_i[0]=1 at cycle 0 -> clk_en_o[0]=1 at cycle 1, cluster_rst_o[0]=0 at cycle 5, iso_o[0]=0 and on_o[0]=1 at cycle 7.
2. en_req_i=5'b11111 simultaneously -> clusters 0 and 1 start at cycles 1 and 2. Cluster 2 starts only after cluster 0 reaches ON. seq_busy_o stays high throughout, and at most 2 clusters are ever transitional.
3. Cluster 3 ON, drop en_req_i[3] with busy_i[3]=1 for 10 cycles -> iso_o[3]=1 next cycle. RST is entered the cycle after busy_i falls; clk_en_o[3]=0 ClkSettle cycles later; err_o[3]=0.
4. busy_i[2] stuck at 1 during power-down -> err_o[2]=1 after 256 DRAIN cycles, then RST and OFF proceed. err_clr_i[2] pulse clears it. Clear asserted in the same cycle as a set leaves the flag at 1.
5. Toggle en_req_i[1] to 0 in DERST -> the cluster still reaches ON, then is granted power-down on the next arbitration.
6. Assert rst_i while clusters are in CLK_ON and DRAIN -> next cycle all outputs at reset values and tokens=0.

Source files
------------

// File: rtl/chimera_cluster_sequencer_pkg.sv
// Shared types and default constants for the Chimera cluster power sequencer.
package chimera_cluster_sequencer_pkg;

  localparam int unsigned ExtClusters            = 5;
  localparam int unsigned ClusterClkSettleCycles = 4;
  localparam int unsigned ClusterIsoSettleCycles = 2;
  localparam int unsigned ClusterDrainTimeout    = 256;

  typedef enum logic [2:0] {
    CsOff   = 3'd0,
    CsClkOn = 3'd1,
    CsDerst = 3'd2,
    CsOn    = 3'd3,
    CsDrain = 3'd4,
    CsRst   = 3'd5
  } cluster_seq_state_e;

  function automatic int unsigned maxOf3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/chimera_cluster_sequencer_fsm.sv
// Per-cluster power sequence: clock enable, reset release, isolation release,
// and drain-before-off, with a sticky drain-timeout flag.
module chimera_cluster_seq_fsm
  import chimera_cluster_sequencer_pkg::*;
#(
  parameter int unsigned ClkSettleCycles = ClusterClkSettleCycles,
  parameter int unsigned IsoSettleCycles = ClusterIsoSettleCycles,
  parameter int unsigned DrainTimeout    = ClusterDrainTimeout
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_req_i,
  input  logic busy_i,
  input  logic err_clr_i,
  input  logic grant_i,
  output logic pend_up_o,
  output logic pend_down_o,
  output logic release_o,
  output logic trans_next_o,
  output logic clk_en_o,
  output logic cluster_rst_o,
  output logic iso_o,
  output logic on_o,
  output logic err_o
);

  localparam int unsigned CntMax = maxOf3(ClkSettleCycles, IsoSettleCycles, DrainTimeout);
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [2:0] StOff   = CsOff;
  localparam logic [2:0] StClkOn = CsClkOn;
  localparam logic [2:0] StDerst = CsDerst;
  localparam logic [2:0] StOn    = CsOn;
  localparam logic [2:0] StDrain = CsDrain;
  localparam logic [2:0] StRst   = CsRst;

  logic [2:0]      state, stateNext;
  logic [CntW-1:0] cnt, cntNext;
  logic            errSet;

  // Next state; the token is handed back when the sequence lands in ON or OFF.
  always_comb begin
    stateNext   = state;
    cntNext     = cnt;
    errSet      = 1'b0;
    release_o   = 1'b0;
    pend_up_o   = (state == StOff) && en_req_i;
    pend_down_o = (state == StOn) && !en_req_i;
    case (state)
      StOff:   if (grant_i) stateNext = StClkOn;
      StClkOn: if (cnt == CntW'(ClkSettleCycles - 1)) stateNext = StDerst;
      StDerst: if (cnt == CntW'(IsoSettleCycles - 1)) begin
                 stateNext = StOn;
                 release_o = 1'b1;
               end
      StOn:    if (grant_i) stateNext = StDrain;
      StDrain: if (!busy_i) begin
                 stateNext = StRst;
               end else if (cnt == CntW'(DrainTimeout - 1)) begin
                 stateNext = StRst;
                 errSet    = 1'b1;
               end
      StRst:   if (cnt == CntW'(ClkSettleCycles - 1)) begin
                 stateNext = StOff;
                 release_o = 1'b1;
               end
      default: stateNext = StOff;
    endcase
    // Counter restarts on every state entry and saturates instead of wrapping.
    if (stateNext != state) begin
      cntNext = '0;
    end else if (cnt != {CntW{1'b1}}) begin
      cntNext = cnt + CntW'(1);
    end
    trans_next_o = !((stateNext == StOff) || (stateNext == StOn));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= StOff;
      cnt           <= '0;
      err_o         <= 1'b0;
      clk_en_o      <= 1'b0;
      cluster_rst_o <= 1'b1;
      iso_o         <= 1'b1;
      on_o          <= 1'b0;
    end else begin
      state         <= stateNext;
      cnt           <= cntNext;
      if (errSet) begin
        err_o <= 1'b1;
      end else if (err_clr_i) begin
        err_o <= 1'b0;
      end
      clk_en_o      <= (stateNext != StOff);
      cluster_rst_o <= (stateNext == StOff) || (stateNext == StClkOn) || (stateNext == StRst);
      iso_o         <= (stateNext != StOn);
      on_o          <= (stateNext == StOn);
    end
  end

endmodule

// File: rtl/chimera_cluster_sequencer.sv
// Cluster power sequencer top: per-cluster FSMs plus an inrush-limiting token
// counter and a lowest-index-first arbiter.
module chimera_cluster_sequencer
  import chimera_cluster_sequencer_pkg::*;
#(
  parameter int unsigned NumClusters     = ExtClusters,
  parameter int unsigned MaxActive       = 2,
  parameter int unsigned ClkSettleCycles = ClusterClkSettleCycles,
  parameter int unsigned IsoSettleCycles = ClusterIsoSettleCycles,
  parameter int unsigned DrainTimeout    = ClusterDrainTimeout
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NumClusters-1:0] en_req_i,
  input  logic [NumClusters-1:0] busy_i,
  input  logic [NumClusters-1:0] err_clr_i,
  output logic [NumClusters-1:0] clk_en_o,
  output logic [NumClusters-1:0] cluster_rst_o,
  output logic [NumClusters-1:0] iso_o,
  output logic [NumClusters-1:0] on_o,
  output logic [NumClusters-1:0] err_o,
  output logic                   seq_busy_o
);

  localparam int unsigned TokW = $clog2(MaxActive + 1);

  logic [NumClusters-1:0] pendUp, pendDown, grant, relBits, transNext;
  logic [TokW-1:0]        tokens, tokensNext;
  logic                   found;

  for (genvar i = 0; i < NumClusters; i++) begin : gCluster
    chimera_cluster_seq_fsm #(
      .ClkSettleCycles(ClkSettleCycles),
      .IsoSettleCycles(IsoSettleCycles),
      .DrainTimeout   (DrainTimeout)
    ) uFsm (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .en_req_i     (en_req_i[i]),
      .busy_i       (busy_i[i]),
      .err_clr_i    (err_clr_i[i]),
      .grant_i      (grant[i]),
      .pend_up_o    (pendUp[i]),
      .pend_down_o  (pendDown[i]),
      .release_o    (relBits[i]),
      .trans_next_o (transNext[i]),
      .clk_en_o     (clk_en_o[i]),
      .cluster_rst_o(cluster_rst_o[i]),
      .iso_o        (iso_o[i]),
      .on_o         (on_o[i]),
      .err_o        (err_o[i])
    );
  end

  // One grant per cycle, lowest pending index first, only while a token is free.
  always_comb begin
    grant = '0;
    found = 1'b0;
    if (tokens < TokW'(MaxActive)) begin
      for (int unsigned i = 0; i < NumClusters; i++) begin
        if (!found && (pendUp[i] || pendDown[i])) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

  always_comb begin
    tokensNext = tokens;
    if (found) tokensNext = tokensNext + TokW'(1);
    for (int unsigned i = 0; i < NumClusters; i++) begin
      if (relBits[i]) tokensNext = tokensNext - TokW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tokens     <= '0;
      seq_busy_o <= 1'b0;
    end else begin
      tokens     <= tokensNext;
      seq_busy_o <= |transNext;
    end
  end

endmodule

// File: tb/tb_chimera_cluster_sequencer.sv
// Self-checking bench: phase/timestamp reference model plus directed and random stimulus.
module tb_chimera_cluster_sequencer;

  localparam int N    = 5;
  localparam int MaxA = 2;
  localparam int C    = 4;
  localparam int I    = 2;
  localparam int D    = 256;

  localparam int PhOff = 0, PhUp = 1, PhOn = 2, PhDrain = 3, PhRst = 4;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [N-1:0] en_req_i, busy_i, err_clr_i;
  logic [N-1:0] clk_en_o, cluster_rst_o, iso_o, on_o, err_o;
  logic         seq_busy_o;

  chimera_cluster_sequencer #(
    .NumClusters(N), .MaxActive(MaxA), .ClkSettleCycles(C),
    .IsoSettleCycles(I), .DrainTimeout(D)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_req_i(en_req_i), .busy_i(busy_i),
    .err_clr_i(err_clr_i), .clk_en_o(clk_en_o), .cluster_rst_o(cluster_rst_o),
    .iso_o(iso_o), .on_o(on_o), .err_o(err_o), .seq_busy_o(seq_busy_o)
  );

  always #5 clk_i = ~clk_i;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  int mPhase[N];
  int mT[N];
  bit mErr[N];
  int mTok;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  // Expected outputs follow from the phase and how long the cluster has been in it.
  task automatic compareAll();
    logic [N-1:0] eClk, eRst, eIso, eOn, eErr;
    logic         eBusy;
    int           nTrans;
    eBusy  = 1'b0;
    nTrans = 0;
    for (int i = 0; i < N; i++) begin
      eClk[i] = (mPhase[i] != PhOff);
      eRst[i] = (mPhase[i] == PhOff) || (mPhase[i] == PhRst) ||
                (mPhase[i] == PhUp && mT[i] < C);
      eIso[i] = (mPhase[i] != PhOn);
      eOn[i]  = (mPhase[i] == PhOn);
      eErr[i] = mErr[i];
      if (mPhase[i] != PhOff && mPhase[i] != PhOn) eBusy = 1'b1;
      if (clk_en_o[i] && !on_o[i]) nTrans++;
    end
    chk("clk_en", 32'(clk_en_o), 32'(eClk));
    chk("cluster_rst", 32'(cluster_rst_o), 32'(eRst));
    chk("iso", 32'(iso_o), 32'(eIso));
    chk("on", 32'(on_o), 32'(eOn));
    chk("err", 32'(err_o), 32'(eErr));
    chk("seq_busy", 32'(seq_busy_o), 32'(eBusy));
    chk("inrush_limit", 32'(nTrans <= MaxA), 32'd1);
  endtask

  task automatic modelStep(input logic r, input logic [N-1:0] en, busy, clr);
    int  nPh[N];
    bit  setE[N];
    int  rel;
    int  g;
    if (r) begin
      for (int i = 0; i < N; i++) begin
        mPhase[i] = PhOff; mT[i] = 0; mErr[i] = 1'b0;
      end
      mTok = 0;
      return;
    end
    rel = 0;
    for (int i = 0; i < N; i++) begin
      nPh[i]  = mPhase[i];
      setE[i] = 1'b0;
      case (mPhase[i])
        PhUp:    if (mT[i] == C + I - 1) begin nPh[i] = PhOn; rel++; end
        PhDrain: if (!busy[i] || mT[i] == D - 1) begin
                   nPh[i] = PhRst;
                   if (busy[i]) setE[i] = 1'b1;
                 end
        PhRst:   if (mT[i] == C - 1) begin nPh[i] = PhOff; rel++; end
        default: ;
      endcase
    end
    g = -1;
    if (mTok < MaxA) begin
      for (int i = 0; i < N; i++) begin
        if (g < 0 && ((mPhase[i] == PhOff && en[i]) || (mPhase[i] == PhOn && !en[i]))) g = i;
      end
    end
    if (g >= 0) nPh[g] = (mPhase[g] == PhOff) ? PhUp : PhDrain;
    for (int i = 0; i < N; i++) begin
      mT[i] = (nPh[i] != mPhase[i]) ? 0 : mT[i] + 1;
      mPhase[i] = nPh[i];
      if (setE[i]) mErr[i] = 1'b1;
      else if (clr[i]) mErr[i] = 1'b0;
    end
    mTok = mTok + ((g >= 0) ? 1 : 0) - rel;
  endtask

  task automatic step(input logic r, input logic [N-1:0] en, busy, clr);
    compareAll();
    rst_i = r; en_req_i = en; busy_i = busy; err_clr_i = clr;
    modelStep(r, en, busy, clr);
    @(posedge clk_i);
    @(negedge clk_i);
    cyc++;
  endtask

  task automatic doReset();
    step(1'b1, '0, '0, '0);
    step(1'b1, '0, '0, '0);
  endtask

  int f1, f2, f3, f4, lows;
  int st[N];
  logic [N-1:0] rEn, rBusy, rClr;
  logic rRst;

  initial begin
    rst_i = 1'b1; en_req_i = '0; busy_i = '0; err_clr_i = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    modelStep(1'b1, '0, '0, '0);
    doReset();
    chk("reset_iso_lit", 32'(iso_o), 32'h1f);
    chk("reset_rst_lit", 32'(cluster_rst_o), 32'h1f);

    // Single cluster power-up timing.
    cyc = 0; f1 = -1; f2 = -1; f3 = -1;
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 5'b00001, '0, '0);
      if (clk_en_o[0] && f1 < 0) f1 = cyc;
      if (!cluster_rst_o[0] && f2 < 0) f2 = cyc;
      if (on_o[0] && !iso_o[0] && f3 < 0) f3 = cyc;
    end
    chk("t1_clk_en_rise", 32'(f1), 32'd1);
    chk("t1_rst_fall", 32'(f2), 32'd5);
    chk("t1_on_rise", 32'(f3), 32'd7);

    // All clusters requested at once: inrush limiter staggers them.
    doReset();
    cyc = 0; lows = 0;
    for (int i = 0; i < N; i++) st[i] = -1;
    for (int k = 0; k < 30; k++) begin
      step(1'b0, 5'b11111, '0, '0);
      for (int i = 0; i < N; i++) if (clk_en_o[i] && st[i] < 0) st[i] = cyc;
      if (cyc >= 1 && cyc <= 20 && !seq_busy_o) lows++;
    end
    chk("t2_start0", 32'(st[0]), 32'd1);
    chk("t2_start1", 32'(st[1]), 32'd2);
    chk("t2_start2", 32'(st[2]), 32'd8);
    chk("t2_start4", 32'(st[4]), 32'd15);
    chk("t2_busy_gaps", 32'(lows), 32'd0);

    // Drain with busy for 10 cycles.
    cyc = 0; f1 = -1; f2 = -1; f3 = -1;
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 5'b10111, (k < 10) ? 5'b01000 : 5'b00000, '0);
      if (iso_o[3] && f1 < 0) f1 = cyc;
      if (cluster_rst_o[3] && f2 < 0) f2 = cyc;
      if (!clk_en_o[3] && f3 < 0) f3 = cyc;
    end
    chk("t3_iso_rise", 32'(f1), 32'd1);
    chk("t3_rst_entry", 32'(f2), 32'd11);
    chk("t3_clk_stop", 32'(f3), 32'd15);
    chk("t3_no_err", 32'(err_o[3]), 32'd0);

    // Drain timeout sets sticky error, then clear.
    doReset();
    for (int k = 0; k < 10; k++) step(1'b0, 5'b00100, '0, '0);
    cyc = 0; f1 = -1; f2 = -1;
    for (int k = 0; k < 270; k++) begin
      step(1'b0, '0, 5'b00100, '0);
      if (err_o[2] && f1 < 0) f1 = cyc;
      if (!clk_en_o[2] && f2 < 0) f2 = cyc;
    end
    chk("t4_err_set", 32'(f1), 32'd257);
    chk("t4_off", 32'(f2), 32'd261);
    step(1'b0, '0, '0, 5'b00100);
    chk("t4_err_cleared", 32'(err_o[2]), 32'd0);

    // Clear coinciding with the timeout: set wins.
    for (int k = 0; k < 10; k++) step(1'b0, 5'b00100, '0, '0);
    cyc = 0;
    for (int k = 0; k < 258; k++) step(1'b0, '0, 5'b00100, (cyc == 256) ? 5'b00100 : 5'b00000);
    chk("t4_set_wins", 32'(err_o[2]), 32'd1);
    step(1'b0, '0, '0, '0);
    chk("t4_still_set", 32'(err_o[2]), 32'd1);

    // Request withdrawn during DERST: completes to ON, then powers down.
    doReset();
    cyc = 0; f1 = -1; f2 = -1;
    for (int k = 0; k < 16; k++) begin
      step(1'b0, (k < 5) ? 5'b00010 : 5'b00000, '0, '0);
      if (on_o[1] && f1 < 0) f1 = cyc;
      if (f1 >= 0 && !on_o[1] && f2 < 0) f2 = cyc;
    end
    chk("t5_on_reached", 32'(f1), 32'd7);
    chk("t5_down_start", 32'(f2), 32'd8);

    // Reset mid-sequence with one cluster draining and one in CLK_ON.
    doReset();
    for (int k = 0; k < 8; k++) step(1'b0, 5'b00001, '0, '0);
    for (int k = 0; k < 3; k++) step(1'b0, 5'b00110, 5'b11111, '0);
    chk("t6_pre_busy", 32'(seq_busy_o), 32'd1);
    step(1'b1, 5'b00110, 5'b11111, '0);
    chk("t6_clk_en", 32'(clk_en_o), 32'h00);
    chk("t6_iso", 32'(iso_o), 32'h1f);
    chk("t6_seq_busy", 32'(seq_busy_o), 32'd0);
    cyc = 0;
    for (int i = 0; i < N; i++) st[i] = -1;
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 5'b11111, '0, '0);
      for (int i = 0; i < N; i++) if (clk_en_o[i] && st[i] < 0) st[i] = cyc;
    end
    chk("t6_tokens_free0", 32'(st[0]), 32'd1);
    chk("t6_tokens_free1", 32'(st[1]), 32'd2);

    // Randomized traffic against the model.
    rEn = '0; rBusy = '0;
    for (int k = 0; k < 4000; k++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(39) == 0) rEn[i] = ~rEn[i];
        if ($urandom_range((i == 4) ? 399 : 7) == 0) rBusy[i] = ~rBusy[i];
        rClr[i] = ($urandom_range(49) == 0);
      end
      rRst = ($urandom_range(499) == 0);
      step(rRst, rEn, rBusy, rClr);
    end
    compareAll();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
